sdram_arbiter: RTL and testbench

//  Shares the single SDRAM controller request port between NUM_PORTS masters (port 0 = VGA line fetcher,
//  1 = CPU data, 2 = blitter/DMA). One transaction in flight at a time; grant held from issue to complete.

---
 rtl/sdram_arbiter_if.sv | 51 +++++
 rtl/sdram_arbiter.sv | 122 ++++++++++++
 tb/tb_sdram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_arbiter_if.sv
// Bundle of master-side request/response signals and SDRAM-controller-side signals
// shared by the arbiter (slave view) and the surrounding masters/controller (master view).
interface sdram_arbiter_if #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 32
);
    localparam int ID_W   = $clog2(NUM_PORTS);
    localparam int MASK_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        port_req;
    logic [NUM_PORTS*ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0]        port_write;
    logic [NUM_PORTS-1:0]        port_burst;
    logic [NUM_PORTS*DATA_W-1:0] port_wdata;
    logic [NUM_PORTS*MASK_W-1:0] port_wmask;
    logic [NUM_PORTS-1:0]        port_ack;
    logic [NUM_PORTS-1:0]        port_rdvalid;
    logic [NUM_PORTS-1:0]        port_complete;
    logic [DATA_W-1:0]           port_rdata;

    logic                        sdram_req;
    logic [ADDR_W-1:0]           sdram_addr;
    logic                        sdram_write;
    logic                        sdram_burst;
    logic [DATA_W-1:0]           sdram_wdata;
    logic [MASK_W-1:0]           sdram_wmask;
    logic                        sdram_ack;
    logic [DATA_W-1:0]           sdram_rdata;
    logic                        sdram_rdvalid;
    logic                        sdram_complete;

    logic                        busy;
    logic [ID_W-1:0]             grant_id;

    modport slave (
        input  port_req, port_addr, port_write, port_burst, port_wdata, port_wmask,
        input  sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete,
        output port_ack, port_rdvalid, port_complete, port_rdata,
        output sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_wdata, sdram_wmask,
        output busy, grant_id
    );

    modport master (
        output port_req, port_addr, port_write, port_burst, port_wdata, port_wmask,
        output sdram_ack, sdram_rdata, sdram_rdvalid, sdram_complete,
        input  port_ack, port_rdvalid, port_complete, port_rdata,
        input  sdram_req, sdram_addr, sdram_write, sdram_burst, sdram_wdata, sdram_wmask,
        input  busy, grant_id
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Single-outstanding SDRAM request arbiter: port 0 has fixed priority, ports 1..N-1
// share round-robin. Read beats and completion are routed only to the current owner.
module sdram_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 26,
    parameter int DATA_W    = 32
) (
    input logic          clk,
    input logic          reset,
    sdram_arbiter_if.slave bus
);
    localparam int ID_W   = $clog2(NUM_PORTS);
    localparam int MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t              state;
    logic [ID_W-1:0]     grant_id;
    logic [ID_W-1:0]     rr_ptr;
    logic                sdram_req;
    logic [ADDR_W-1:0]   addr_q;
    logic                write_q;
    logic                burst_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [MASK_W-1:0]   wmask_q;

    logic [ID_W-1:0]      winner;
    logic [ID_W-1:0]      win_hi;
    logic [ID_W-1:0]      win_lo;
    logic                 hit_hi;
    logic [ID_W-1:0]      rr_next;
    logic [NUM_PORTS-1:0] owner;

    // Lowest requester at/after rr_ptr wins; otherwise wrap to the lowest requester >= 1.
    always_comb begin
        win_hi = '0;
        win_lo = '0;
        hit_hi = 1'b0;
        for (int p = NUM_PORTS - 1; p >= 1; p--) begin
            if (bus.port_req[p]) begin
                win_lo = ID_W'(p);
                if (ID_W'(p) >= rr_ptr) begin
                    win_hi = ID_W'(p);
                    hit_hi = 1'b1;
                end
            end
        end
        if (bus.port_req[0]) begin
            winner = '0;
        end else if (hit_hi) begin
            winner = win_hi;
        end else begin
            winner = win_lo;
        end
    end

    assign rr_next = (grant_id == ID_W'(NUM_PORTS - 1)) ? ID_W'(1) : grant_id + ID_W'(1);
    assign owner   = NUM_PORTS'(1) << grant_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            sdram_req <= 1'b0;
            grant_id  <= '0;
            rr_ptr    <= ID_W'(1);
            addr_q    <= '0;
            write_q   <= 1'b0;
            burst_q   <= 1'b0;
            wdata_q   <= '0;
            wmask_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.port_req) begin
                        addr_q    <= bus.port_addr[int'(winner)*ADDR_W +: ADDR_W];
                        write_q   <= bus.port_write[winner];
                        burst_q   <= bus.port_burst[winner] & ~bus.port_write[winner];
                        wdata_q   <= bus.port_wdata[int'(winner)*DATA_W +: DATA_W];
                        wmask_q   <= bus.port_wmask[int'(winner)*MASK_W +: MASK_W];
                        grant_id  <= winner;
                        sdram_req <= 1'b1;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.sdram_ack) begin
                        sdram_req <= 1'b0;
                        if (bus.sdram_complete) begin
                            state <= IDLE;
                            if (grant_id != '0) rr_ptr <= rr_next;
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (bus.sdram_complete) begin
                        state <= IDLE;
                        if (grant_id != '0) rr_ptr <= rr_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.port_ack      = (state == ISSUE && bus.sdram_ack) ? owner : '0;
    assign bus.port_rdvalid  = (state == WAIT && bus.sdram_rdvalid) ? owner : '0;
    // A write retired in the same cycle as its ack still owes the owner its completion pulse.
    assign bus.port_complete = (bus.sdram_complete &&
                                (state == WAIT || (state == ISSUE && bus.sdram_ack))) ? owner : '0;
    assign bus.port_rdata    = bus.sdram_rdata;

    assign bus.sdram_req   = sdram_req;
    assign bus.sdram_addr  = addr_q;
    assign bus.sdram_write = write_q;
    assign bus.sdram_burst = burst_q;
    assign bus.sdram_wdata = wdata_q;
    assign bus.sdram_wmask = wmask_q;
    assign bus.busy        = (state != IDLE);
    assign bus.grant_id    = grant_id;
endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized checks of sdram_arbiter against a queue-free arbitration model
// (priority port 0, round-robin distance among the rest) and a simple controller model.
module tb_sdram_arbiter;
    localparam int N  = 3;
    localparam int AW = 26;
    localparam int DW = 32;
    localparam int MW = DW / 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sdram_arbiter_if #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbiter #(.NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [N-1:0]  req;
    logic [N-1:0]  rereq;
    logic [AW-1:0] p_addr  [N];
    logic          p_wr    [N];
    logic          p_burst [N];
    logic [DW-1:0] p_wdata [N];
    logic [MW-1:0] p_wmask [N];

    int            rr_m = 1;
    int            last_w = 0;
    logic [AW-1:0] lat_addr;
    int            lat_beats;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_ports();
        bus.port_req = req;
        for (int i = 0; i < N; i++) begin
            bus.port_addr[i*AW +: AW]  = p_addr[i];
            bus.port_write[i]          = p_wr[i];
            bus.port_burst[i]          = p_burst[i];
            bus.port_wdata[i*DW +: DW] = p_wdata[i];
            bus.port_wmask[i*MW +: MW] = p_wmask[i];
        end
    endtask

    task automatic ctrl_idle();
        bus.sdram_ack      = 1'b0;
        bus.sdram_rdvalid  = 1'b0;
        bus.sdram_complete = 1'b0;
        bus.sdram_rdata    = '0;
    endtask

    task automatic new_params(input int p);
        p_addr[p]  = AW'($urandom);
        p_wr[p]    = ($urandom_range(0, 2) == 0);
        p_burst[p] = ($urandom_range(0, 1) == 1);
        p_wdata[p] = $urandom;
        p_wmask[p] = MW'($urandom);
    endtask

    // Reference arbitration: port 0 first, else smallest forward distance from the rr pointer.
    function automatic int pick(input logic [N-1:0] r);
        int best;
        int bestd;
        int d;
        best  = -1;
        bestd = N;
        if (r[0]) return 0;
        for (int p = 1; p < N; p++) begin
            if (r[p]) begin
                d = (p - rr_m + (N - 1)) % (N - 1);
                if (d < bestd) begin
                    bestd = d;
                    best  = p;
                end
            end
        end
        return best;
    endfunction

    task automatic upd_rr(input int w);
        if (w != 0) rr_m = (w % (N - 1)) + 1;
        last_w = w;
    endtask

    // Entered just after a negedge with the DUT idle and req non-zero. ac_mode: 0 never,
    // 1 always, 2 randomly retire a write in the ack cycle.
    task automatic start_txn(input int ac_mode, output int w, output bit ack_cmpl);
        int steps;
        int hold;
        w = pick(req);
        steps = 0;
        do begin
            @(negedge clk);
            #1;
            steps++;
        end while (!bus.sdram_req && steps < 10);
        chk("turnaround", 64'(steps), 64'(1));
        chk("grant_id", 64'(bus.grant_id), 64'(w));
        chk("busy_issue", 64'(bus.busy), 64'(1));
        chk("sdram_addr", 64'(bus.sdram_addr), 64'(p_addr[w]));
        chk("sdram_write", 64'(bus.sdram_write), 64'(p_wr[w]));
        chk("sdram_burst", 64'(bus.sdram_burst), 64'(p_burst[w] & ~p_wr[w]));
        if (p_wr[w]) begin
            chk("sdram_wdata", 64'(bus.sdram_wdata), 64'(p_wdata[w]));
            chk("sdram_wmask", 64'(bus.sdram_wmask), 64'(p_wmask[w]));
        end
        lat_addr  = p_addr[w];
        lat_beats = p_wr[w] ? 0 : (p_burst[w] ? 16 : 1);
        ack_cmpl  = p_wr[w] && (ac_mode == 1 || (ac_mode == 2 && $urandom_range(0, 1) == 1));
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            #1;
            chk("ack_early", 64'(bus.port_ack), 64'(0));
            chk("req_hold", 64'(bus.sdram_req), 64'(1));
        end
        @(negedge clk);
        bus.sdram_ack      = 1'b1;
        bus.sdram_complete = ack_cmpl;
        #1;
        chk("port_ack", 64'(bus.port_ack), 64'(1) << w);
        if (ack_cmpl) chk("complete_at_ack", 64'(bus.port_complete), 64'(1) << w);
        @(negedge clk);
        ctrl_idle();
        req[w] = rereq[w];
        if (rereq[w]) new_params(w);
        drive_ports();
        #1;
        chk("req_drop", 64'(bus.sdram_req), 64'(0));
        chk("busy_after_ack", 64'(bus.busy), 64'(!ack_cmpl));
        chk("rdvalid_quiet", 64'(bus.port_rdvalid), 64'(0));
        if (ack_cmpl) upd_rr(w);
    endtask

    task automatic finish_txn(input int w, input int beats);
        logic [DW-1:0] d;
        for (int b = 0; b < beats; b++) begin
            @(negedge clk);
            bus.sdram_rdvalid = 1'b0;
            if ($urandom_range(0, 3) == 0) begin
                #1;
                chk("gap_rdvalid", 64'(bus.port_rdvalid), 64'(0));
                @(negedge clk);
            end
            d = $urandom;
            bus.sdram_rdata   = d;
            bus.sdram_rdvalid = 1'b1;
            #1;
            chk("port_rdvalid", 64'(bus.port_rdvalid), 64'(1) << w);
            chk("port_rdata", 64'(bus.port_rdata), 64'(d));
        end
        @(negedge clk);
        bus.sdram_rdvalid  = 1'b0;
        bus.sdram_complete = 1'b1;
        #1;
        chk("port_complete", 64'(bus.port_complete), 64'(1) << w);
        chk("addr_hold", 64'(bus.sdram_addr), 64'(lat_addr));
        chk("rdvalid_at_complete", 64'(bus.port_rdvalid), 64'(0));
        @(negedge clk);
        ctrl_idle();
        #1;
        chk("busy_after_complete", 64'(bus.busy), 64'(0));
        chk("complete_pulse", 64'(bus.port_complete), 64'(0));
        upd_rr(w);
    endtask

    task automatic txn(input int ac_mode);
        int w;
        bit ac;
        start_txn(ac_mode, w, ac);
        if (!ac) finish_txn(w, lat_beats);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        bit ac;
        logic [DW-1:0] d;

        req   = '0;
        rereq = '0;
        for (int i = 0; i < N; i++) begin
            p_addr[i]  = '0;
            p_wr[i]    = 1'b0;
            p_burst[i] = 1'b0;
            p_wdata[i] = '0;
            p_wmask[i] = '0;
        end
        drive_ports();
        ctrl_idle();

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_sdram_req", 64'(bus.sdram_req), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_grant_id", 64'(bus.grant_id), 64'(0));
        chk("rst_port_out", 64'({bus.port_ack, bus.port_rdvalid, bus.port_complete}), 64'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Port 0 burst read alone
        p_addr[0]  = AW'(26'h0001040);
        p_wr[0]    = 1'b0;
        p_burst[0] = 1'b1;
        req        = 3'b001;
        drive_ports();
        txn(0);

        // Port 1 write with burst flag set, retired in the ack cycle
        p_addr[1]  = AW'(26'h0000100);
        p_wr[1]    = 1'b1;
        p_burst[1] = 1'b1;
        p_wdata[1] = 32'hDEADBEEF;
        p_wmask[1] = 4'b0011;
        req        = 3'b010;
        drive_ports();
        txn(1);

        // Stray controller responses while idle
        @(negedge clk);
        bus.sdram_rdvalid  = 1'b1;
        bus.sdram_complete = 1'b1;
        #1;
        chk("stray_rdvalid", 64'(bus.port_rdvalid), 64'(0));
        chk("stray_complete", 64'(bus.port_complete), 64'(0));
        @(negedge clk);
        ctrl_idle();
        #1;
        chk("stray_busy", 64'(bus.busy), 64'(0));
        chk("stray_grant", 64'(bus.grant_id), 64'(last_w));
        chk("stray_req", 64'(bus.sdram_req), 64'(0));

        // Ports 1 and 2 requesting continuously, port 0 cuts in mid-stream
        new_params(1);
        new_params(2);
        req   = 3'b110;
        rereq = 3'b110;
        drive_ports();
        txn(2);
        txn(2);
        new_params(0);
        req[0] = 1'b1;
        drive_ports();
        txn(2);
        txn(2);
        txn(2);

        // Reset in the middle of a port 0 burst
        p_wr[0]    = 1'b0;
        p_burst[0] = 1'b1;
        req        = 3'b111;
        drive_ports();
        start_txn(0, w, ac);
        for (int b = 0; b < 7; b++) begin
            @(negedge clk);
            d = $urandom;
            bus.sdram_rdata   = d;
            bus.sdram_rdvalid = 1'b1;
            #1;
            chk("pre_rst_rdvalid", 64'(bus.port_rdvalid), 64'(1) << w);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.sdram_complete = 1'b1;
        #1;
        chk("midrst_req", 64'(bus.sdram_req), 64'(0));
        chk("midrst_busy", 64'(bus.busy), 64'(0));
        chk("midrst_grant", 64'(bus.grant_id), 64'(0));
        chk("midrst_ports", 64'({bus.port_ack, bus.port_rdvalid, bus.port_complete}), 64'(0));
        @(negedge clk);
        ctrl_idle();
        reset = 1'b0;
        rr_m  = 1;
        #1;
        txn(2);

        // Randomized traffic
        for (int i = 0; i < N; i++) new_params(i);
        for (int t = 0; t < 40; t++) begin
            req   = req | {N'($urandom) & {{(N-1){1'b1}}, ($urandom_range(0, 3) == 0)}};
            if (req == '0) req[$urandom_range(1, N - 1)] = 1'b1;
            rereq = N'($urandom);
            drive_ports();
            txn(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
